// File: rtl/uart_tx_cfg.sv
// ============================================================================
//  Module   : uart_tx_cfg
//  Purpose  : Runtime-configurable UART transmitter (5..9 data bits, optional
//             even/odd parity, 1 or 2 stop bits, runtime baud divisor).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_cfg #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic              parity_en,
    input  logic              parity_odd,
    input  logic              stop2,
    output logic              Tx,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int              IDX_W    = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t             state_q;
    logic [DATA_W-1:0]  shift_q;
    logic [DIV_W-1:0]   div_m1_q;
    logic [DIV_W-1:0]   baud_cnt_q;
    logic [IDX_W-1:0]   bit_idx_q;
    logic               par_en_q;
    logic               par_bit_q;
    logic               stop2_q;
    logic               tx_q;
    logic               busy_q;
    logic               done_q;

    logic [DIV_W-1:0]   div_m1_d;
    logic               par_bit_d;
    logic               bit_end;

    // A divisor of 0 is folded onto 1, so the terminal count is 0 for both.
    assign div_m1_d  = (baud_div == '0) ? '0 : (baud_div - DIV_W'(1));
    assign par_bit_d = (^tx_data) ^ parity_odd;
    assign bit_end   = (baud_cnt_q == div_m1_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            div_m1_q   <= '0;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == S_IDLE) begin
                if (tx_valid) begin
                    state_q    <= S_START;
                    tx_q       <= 1'b0;
                    busy_q     <= 1'b1;
                    shift_q    <= tx_data;
                    div_m1_q   <= div_m1_d;
                    baud_cnt_q <= '0;
                    bit_idx_q  <= '0;
                    par_en_q   <= parity_en;
                    par_bit_q  <= par_bit_d;
                    stop2_q    <= stop2;
                end
            end else if (!bit_end) begin
                baud_cnt_q <= baud_cnt_q + DIV_W'(1);
            end else begin
                baud_cnt_q <= '0;
                case (state_q)
                    S_START: begin
                        state_q   <= S_DATA;
                        tx_q      <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                        bit_idx_q <= '0;
                    end
                    S_DATA: begin
                        if (bit_idx_q == LAST_IDX) begin
                            bit_idx_q <= '0;
                            if (par_en_q) begin
                                state_q <= S_PARITY;
                                tx_q    <= par_bit_q;
                            end else begin
                                state_q <= S_STOP;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + IDX_W'(1);
                            tx_q      <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                        end
                    end
                    S_PARITY: begin
                        state_q   <= S_STOP;
                        tx_q      <= 1'b1;
                        bit_idx_q <= '0;
                    end
                    S_STOP: begin
                        // bit_idx doubles as the stop-bit counter here.
                        if (stop2_q && (bit_idx_q == '0)) begin
                            bit_idx_q <= IDX_W'(1);
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        tx_q    <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tx_ready = (state_q == S_IDLE);
    assign Tx       = tx_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

endmodule

`default_nettype wire
